dmem_arbiter: RTL and testbench

Two-port arbiter sharing the single-port data memory (512 words addressed by 9 bits) between the core load/store path and a debug/loader port. The core has fixed priority. A bounded-wait counter guarantees the debug port service, and a lock mode lets the debug port run uninterrupted bursts. It sits between the datapath memory signals (`wr`, `rd`, `addr`, `wr_data`, `rd_data`) and the data memory. It drives a stall to the core whenever the core's request loses arbitration.

---
 rtl/dmem_arb_pkg.sv | 12 +
 rtl/dmem_rd_tracker.sv | 54 +++++
 rtl/dmem_arbiter.sv | 113 +++++++++++
 tb/tb_dmem_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding and read-owner tags.
package dmem_arb_pkg;

  typedef enum logic {
    ARB   = 1'b0,
    DLOCK = 1'b1
  } arb_state_t;

  localparam logic OWN_CORE = 1'b0;
  localparam logic OWN_DBG  = 1'b1;

endpackage

// File: rtl/dmem_rd_tracker.sv
// Remembers who issued the last memory read and steers the returning data
// to that port one cycle later.
module dmem_rd_tracker
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_issue,
  input  logic              rd_owner,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata
);

  logic pend_q, pend_d;
  logic owner_q, owner_d;

  always_comb begin
    pend_d  = rd_issue;
    owner_d = rd_issue ? rd_owner : owner_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q  <= 1'b0;
      owner_q <= OWN_CORE;
    end else begin
      pend_q  <= pend_d;
      owner_q <= owner_d;
    end
  end

  // A read pending across a reset edge is dropped: the return is masked while reset is high.
  always_comb begin
    c_rvalid = 1'b0;
    d_rvalid = 1'b0;
    c_rdata  = '0;
    d_rdata  = '0;
    if (pend_q && !reset) begin
      if (owner_q == OWN_CORE) begin
        c_rvalid = 1'b1;
        c_rdata  = mem_rd_data;
      end else begin
        d_rvalid = 1'b1;
        d_rdata  = mem_rd_data;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core (fixed priority) and a
// debug/loader port with bounded wait and an optional burst lock.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 9,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  output logic              core_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_lock,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  arb_state_t state_q, state_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       lock_hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ARB;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // The lock only holds while d_lock stays high; the cycle it drops is arbitrated normally.
  always_comb begin
    c_gnt      = 1'b0;
    d_gnt      = 1'b0;
    wait_cnt_d = wait_cnt_q;
    lock_hold  = (state_q == DLOCK) && d_lock;

    if (!reset) begin
      if (lock_hold) begin
        d_gnt = d_req;
      end else if (c_req && d_req) begin
        if (wait_cnt_q >= MAX_WAIT_C) d_gnt = 1'b1;
        else                          c_gnt = 1'b1;
      end else begin
        c_gnt = c_req;
        d_gnt = d_req;
      end
    end

    state_d = ((d_gnt && d_lock) || lock_hold) ? DLOCK : ARB;

    if (!d_req || d_gnt) begin
      wait_cnt_d = '0;
    end else if (c_gnt && (wait_cnt_q < MAX_WAIT_C)) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  assign core_stall = c_req && !c_gnt && !reset;

  always_comb begin
    mem_wr      = 1'b0;
    mem_rd      = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    if (c_gnt) begin
      mem_wr      = c_we;
      mem_rd      = !c_we;
      mem_addr    = c_addr;
      mem_wr_data = c_wdata;
    end else if (d_gnt) begin
      mem_wr      = d_we;
      mem_rd      = !d_we;
      mem_addr    = d_addr;
      mem_wr_data = d_wdata;
    end
  end

  dmem_rd_tracker #(
    .DATA_W(DATA_W)
  ) u_rd_tracker (
    .clk        (clk),
    .reset      (reset),
    .rd_issue   (mem_rd),
    .rd_owner   (d_gnt ? OWN_DBG : OWN_CORE),
    .mem_rd_data(mem_rd_data),
    .c_rvalid   (c_rvalid),
    .c_rdata    (c_rdata),
    .d_rvalid   (d_rvalid),
    .d_rdata    (d_rdata)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic, all checked
// every cycle against a behavioural arbitration/memory model.
module tb_dmem_arbiter;

  localparam int DW = 32;
  localparam int AW = 9;
  localparam int MW = 4;

  logic          clk;
  logic          reset;
  logic          c_req, c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic          c_gnt, c_rvalid, core_stall;
  logic [DW-1:0] c_rdata;
  logic          d_req, d_we, d_lock;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_wr, mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data;
  logic [DW-1:0] memRdData;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] tbMem  [512];
  logic [DW-1:0] shadow [512];

  bit            mLocked;
  int            mWait;
  bit            mPendValid;
  bit            mPendDbg;
  logic [DW-1:0] mPendData;

  dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .core_stall(core_stall),
    .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(memRdData)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single-port memory: write at the edge, read data registered one cycle later.
  initial begin
    for (int i = 0; i < 512; i++) tbMem[i] = 32'(i * 3 + 1);
    memRdData = '0;
    forever begin
      @(posedge clk);
      if (mem_wr) tbMem[mem_addr] = mem_wr_data;
      if (mem_rd) memRdData <= tbMem[mem_addr];
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit cr, input bit cw, input logic [AW-1:0] ca,
                               input logic [DW-1:0] cd, input bit dr, input bit dw,
                               input bit dl, input logic [AW-1:0] da, input logic [DW-1:0] dd);
    c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
    d_req = dr; d_we = dw; d_lock = dl; d_addr = da; d_wdata = dd;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Reference model: evaluated mid-cycle on stable inputs, then advanced for the next cycle.
  initial begin
    bit            eC, eD, lockNow, eWr, eRd, eCv, eDv;
    logic [AW-1:0] eAddr;
    logic [DW-1:0] eWd, eCd, eDd;
    for (int i = 0; i < 512; i++) shadow[i] = 32'(i * 3 + 1);
    mLocked = 0; mWait = 0; mPendValid = 0; mPendDbg = 0; mPendData = '0;
    forever begin
      @(negedge clk);
      eC = 0; eD = 0; lockNow = 0; eWr = 0; eRd = 0; eCv = 0; eDv = 0;
      eAddr = '0; eWd = '0; eCd = '0; eDd = '0;
      if (!reset) begin
        lockNow = mLocked && d_lock;
        if (lockNow)             eD = d_req;
        else if (c_req && d_req) begin
          if (mWait >= MW) eD = 1;
          else             eC = 1;
        end else begin
          eC = c_req;
          eD = d_req;
        end
        if (eC) begin
          eWr = c_we; eRd = !c_we; eAddr = c_addr; eWd = c_wdata;
        end else if (eD) begin
          eWr = d_we; eRd = !d_we; eAddr = d_addr; eWd = d_wdata;
        end
        if (mPendValid && mPendDbg)  begin eDv = 1; eDd = mPendData; end
        if (mPendValid && !mPendDbg) begin eCv = 1; eCd = mPendData; end
      end
      checkOutput("grants", 64'({c_gnt, d_gnt, core_stall}),
                  64'({eC, eD, c_req && !eC && !reset}));
      checkOutput("memcmd", 64'({mem_wr, mem_rd, mem_addr, mem_wr_data}),
                  64'({eWr, eRd, eAddr, eWd}));
      checkOutput("core_ret", 64'({c_rvalid, c_rdata}), 64'({eCv, eCd}));
      checkOutput("dbg_ret", 64'({d_rvalid, d_rdata}), 64'({eDv, eDd}));
      if (reset) begin
        mLocked = 0; mWait = 0; mPendValid = 0;
      end else begin
        mPendValid = eRd;
        mPendDbg   = eD;
        if (eRd) mPendData = shadow[eAddr];
        if (eWr) shadow[eAddr] = eWd;
        mLocked = (eD && d_lock) || lockNow;
        if (!d_req || eD) mWait = 0;
        else if (eC)      mWait = (mWait + 1 > MW) ? MW : mWait + 1;
      end
    end
  end

  initial begin
    bit cg, dg;
    reset = 1'b1;
    applyStimulus(0, 0, '0, '0, 0, 0, 0, '0, '0);
    @(negedge clk);
    checkOutput("reset_outs", 64'({c_gnt, d_gnt, core_stall, c_rvalid, d_rvalid, mem_wr, mem_rd}), 64'd0);
    stepCycle();
    stepCycle();
    reset = 1'b0;

    // Core only: write then read back.
    applyStimulus(1, 1, 9'd5, 32'hDEADBEEF, 0, 0, 0, '0, '0);
    @(negedge clk);
    checkOutput("core_wr_gnt", 64'({c_gnt, core_stall, mem_wr}), 64'b101);
    stepCycle();
    applyStimulus(1, 0, 9'd5, '0, 0, 0, 0, '0, '0);
    @(negedge clk);
    checkOutput("core_rd_gnt", 64'({c_gnt, core_stall, mem_rd}), 64'b101);
    stepCycle();
    applyStimulus(0, 0, '0, '0, 0, 0, 0, '0, '0);
    @(negedge clk);
    checkOutput("core_rd_data", 64'({c_rvalid, c_rdata}), {31'd0, 1'b1, 32'hDEADBEEF});
    stepCycle();

    // Continuous contention: core x4 then debug x1.
    applyStimulus(1, 0, 9'd1, '0, 1, 0, 0, 9'd2, '0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput($sformatf("contend%0d", i), 64'({c_gnt, d_gnt, core_stall}),
                  (i % 5 == 4) ? 64'b011 : 64'b100);
      stepCycle();
    end

    // Forced grant with lock, then a locked write burst.
    applyStimulus(1, 0, 9'd1, '0, 1, 0, 1, 9'd3, '0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("lock_entry%0d", i), 64'({c_gnt, d_gnt, core_stall}),
                  (i == 4) ? 64'b011 : 64'b100);
      stepCycle();
    end
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 1, 9'd9, 32'h55, 1, 1, 1, 9'(k), 32'hA0 + 32'(k));
      @(negedge clk);
      checkOutput($sformatf("lock_wr%0d", k), 64'({c_gnt, d_gnt, core_stall, mem_wr, mem_addr}),
                  64'({4'b0111, 9'(k)}));
      stepCycle();
    end
    applyStimulus(1, 1, 9'd9, 32'h55, 0, 0, 0, '0, '0);
    @(negedge clk);
    checkOutput("unlock_core", 64'({c_gnt, d_gnt, core_stall, mem_wr}), 64'b1001);
    stepCycle();

    // Locked but debug idle: the memory must stay idle and the core stalled.
    applyStimulus(0, 0, '0, '0, 1, 0, 1, 9'd4, '0);
    @(negedge clk);
    checkOutput("dlock_enter", 64'(d_gnt), 64'd1);
    stepCycle();
    applyStimulus(1, 1, 9'd10, 32'h66, 0, 0, 1, '0, '0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("dlock_idle", 64'({c_gnt, d_gnt, core_stall, mem_wr, mem_rd}), 64'b00100);
      stepCycle();
    end
    applyStimulus(1, 1, 9'd10, 32'h66, 0, 0, 0, '0, '0);
    @(negedge clk);
    checkOutput("dlock_exit", 64'({c_gnt, d_gnt, core_stall, mem_wr, mem_rd}), 64'b10010);
    stepCycle();

    // Mixed reads from both ports on consecutive cycles.
    applyStimulus(0, 0, '0, '0, 1, 1, 0, 9'd7, 32'h11);
    stepCycle();
    applyStimulus(1, 1, 9'd8, 32'h22, 0, 0, 0, '0, '0);
    stepCycle();
    applyStimulus(0, 0, '0, '0, 1, 0, 0, 9'd7, '0);
    @(negedge clk);
    checkOutput("dbg_rd_gnt", 64'({d_gnt, mem_rd, mem_addr}), 64'({2'b11, 9'd7}));
    stepCycle();
    applyStimulus(1, 0, 9'd8, '0, 0, 0, 0, '0, '0);
    @(negedge clk);
    checkOutput("mixed_d_ret", 64'({d_rvalid, d_rdata}), {31'd0, 1'b1, 32'h11});
    checkOutput("mixed_c_zero", 64'({c_rvalid, c_rdata}), 64'd0);
    stepCycle();
    applyStimulus(0, 0, '0, '0, 0, 0, 0, '0, '0);
    @(negedge clk);
    checkOutput("mixed_c_ret", 64'({c_rvalid, c_rdata}), {31'd0, 1'b1, 32'h22});
    checkOutput("mixed_d_zero", 64'({d_rvalid, d_rdata}), 64'd0);
    stepCycle();

    // Reset right after a read issue: the read must never return.
    applyStimulus(1, 0, 9'd5, '0, 0, 0, 0, '0, '0);
    stepCycle();
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_outs", 64'({c_gnt, d_gnt, core_stall, c_rvalid, d_rvalid, mem_wr, mem_rd, mem_addr}), 64'd0);
    checkOutput("rst_mid_rdata", 64'(c_rdata), 64'd0);
    stepCycle();
    reset = 1'b0;
    applyStimulus(1, 0, 9'd1, '0, 1, 0, 0, 9'd2, '0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) checkOutput("rst_no_rvalid", 64'(c_rvalid), 64'd0);
      checkOutput($sformatf("rst_contend%0d", i), 64'({c_gnt, d_gnt}), (i == 4) ? 64'b01 : 64'b10);
      stepCycle();
    end

    // Randomized traffic obeying the hold-until-grant protocol.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      cg = c_gnt;
      dg = d_gnt;
      @(posedge clk);
      #1;
      reset = ($urandom_range(0, 199) == 0);
      if (!c_req || cg) begin
        c_req   = ($urandom_range(0, 3) != 0);
        c_we    = $urandom_range(0, 1) == 1;
        c_addr  = 9'($urandom_range(0, 15));
        c_wdata = $urandom;
      end
      if (!d_req || dg) begin
        d_req   = ($urandom_range(0, 2) == 0);
        d_we    = $urandom_range(0, 1) == 1;
        d_addr  = 9'($urandom_range(0, 15));
        d_wdata = $urandom;
      end
      if ($urandom_range(0, 7) == 0) d_lock = !d_lock;
    end

    reset = 1'b0;
    applyStimulus(0, 0, '0, '0, 0, 0, 0, '0, '0);
    repeat (3) stepCycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
